cnn_job_sequencer: RTL and testbench

- AHB-Lite master that sequences the CNN accelerator through its slave register port.
- Accepts job descriptors (image address + config word) into a small queue. For each job it programs IMG_ADDR and CFG, writes START, then polls STATUS until done.
- Attaches to an AHB interconnect master slot. Replaces hand-driven register writes from the dummy RISC master.

---
 rtl/cnn_job_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_cnn_job_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_job_sequencer.sv
// rtl/cnn_job_sequencer.sv - AHB-Lite master that queues CNN jobs and drives the accelerator registers
// Optional macro CNN_JOB_SEQ_POLL_TIMEOUT_EN bounds STATUS polling to POLL_MAX reads.
module cnn_job_sequencer #(
  parameter logic [31:0] CNN_BASE = 32'h2000_0000,
  parameter int          Q_DEPTH  = 4,
  parameter int          POLL_GAP = 8,
  parameter int          POLL_MAX = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_img_addr,
  input  logic [31:0] job_cfg,
  output logic [31:0] out_HADDR,
  output logic [1:0]  out_HTRANS,
  output logic        out_HWRITE,
  output logic [2:0]  out_HSIZE,
  output logic [2:0]  out_HBURST,
  output logic [31:0] out_HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA,
  output logic        busy,
  output logic        job_done,
  output logic        job_err,
  output logic [15:0] done_cnt
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(Q_DEPTH);
  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [1:0]  RESP_ERR  = 2'b01;
  localparam logic [31:0] A_CTRL   = CNN_BASE + 32'h00;
  localparam logic [31:0] A_STATUS = CNN_BASE + 32'h04;
  localparam logic [31:0] A_IMG    = CNN_BASE + 32'h08;
  localparam logic [31:0] A_CFG    = CNN_BASE + 32'h0C;

  typedef enum logic [2:0] {
    S_IDLE, S_W_IMG, S_W_CFG, S_W_START, S_POLL, S_GAP, S_W_CTRL, S_FIN
  } state_t;

  state_t        state_q;
  logic          dphase_q;
  logic          stop_q;
  logic [31:0]   img_q, cfg_q;
  logic [GW-1:0] gap_q;
  logic [31:0]   haddr_q, hwdata_q, wdata_c;
  logic [1:0]    htrans_q;
  logic          hwrite_q;
  logic          busy_q, job_done_q, job_err_q, job_ready_q;
  logic [15:0]   done_cnt_q;

  logic [31:0]   q_img_q [Q_DEPTH];
  logic [31:0]   q_cfg_q [Q_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
  logic [31:0]   poll_cnt_q;
`else
  localparam int unused_poll_max = POLL_MAX;
`endif

  // Only the done bit of STATUS matters to the sequencer.
  logic unused_hrdata;
  assign unused_hrdata = ^{HRDATA[31:2], HRDATA[0]};

  assign push    = job_valid && job_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_ff @(posedge HCLK) begin
    if (push) begin
      q_img_q[wr_ptr_q] <= job_img_addr;
      q_cfg_q[wr_ptr_q] <= job_cfg;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      job_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      job_ready_q <= (count_d != FULL_CNT);
    end
  end

  always_comb begin
    wdata_c = 32'h0;
    case (state_q)
      S_W_IMG:   wdata_c = img_q;
      S_W_CFG:   wdata_c = cfg_q;
      S_W_START: wdata_c = 32'h1;
      S_W_CTRL:  wdata_c = stop_q ? 32'h0 : 32'h2;
      default:   wdata_c = 32'h0;
    endcase
  end

  // Each register access is one NONSEQ address phase followed by its data phase;
  // the next address phase is only issued once the previous data phase completes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      dphase_q   <= 1'b0;
      stop_q     <= 1'b0;
      img_q      <= '0;
      cfg_q      <= '0;
      gap_q      <= '0;
      haddr_q    <= '0;
      htrans_q   <= HT_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      done_cnt_q <= '0;
`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            img_q    <= q_img_q[rd_ptr_q];
            cfg_q    <= q_cfg_q[rd_ptr_q];
            state_q  <= S_W_IMG;
            busy_q   <= 1'b1;
            htrans_q <= HT_NONSEQ;
            haddr_q  <= A_IMG;
            hwrite_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GW'(POLL_GAP - 1)) begin
            state_q  <= S_POLL;
            htrans_q <= HT_NONSEQ;
            haddr_q  <= A_STATUS;
            hwrite_q <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          if (!dphase_q) begin
            if (HREADY) begin
              htrans_q <= HT_IDLE;
              dphase_q <= 1'b1;
              hwdata_q <= wdata_c;
            end
          end else if (HRESP == RESP_ERR) begin
            // Abandon the job; queued jobs are untouched.
            dphase_q  <= 1'b0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            job_err_q <= 1'b1;
          end else if (HREADY) begin
            dphase_q <= 1'b0;
            case (state_q)
              S_W_IMG: begin
                state_q  <= S_W_CFG;
                htrans_q <= HT_NONSEQ;
                haddr_q  <= A_CFG;
              end
              S_W_CFG: begin
                state_q  <= S_W_START;
                htrans_q <= HT_NONSEQ;
                haddr_q  <= A_CTRL;
`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
                poll_cnt_q <= '0;
`endif
              end
              S_W_START: begin
                state_q  <= S_POLL;
                htrans_q <= HT_NONSEQ;
                haddr_q  <= A_STATUS;
                hwrite_q <= 1'b0;
              end
              S_POLL: begin
`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
                poll_cnt_q <= poll_cnt_q + 32'd1;
`endif
                if (HRDATA[1]) begin
                  state_q  <= S_W_CTRL;
                  stop_q   <= 1'b0;
                  htrans_q <= HT_NONSEQ;
                  haddr_q  <= A_CTRL;
                  hwrite_q <= 1'b1;
                end
`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
                else if (poll_cnt_q == 32'(POLL_MAX - 1)) begin
                  state_q  <= S_W_CTRL;
                  stop_q   <= 1'b1;
                  htrans_q <= HT_NONSEQ;
                  haddr_q  <= A_CTRL;
                  hwrite_q <= 1'b1;
                end
`endif
                else begin
                  state_q <= S_GAP;
                  gap_q   <= '0;
                end
              end
              S_W_CTRL: begin
                if (stop_q) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  job_err_q <= 1'b1;
                end else begin
                  state_q    <= S_FIN;
                  job_done_q <= 1'b1;
                  done_cnt_q <= done_cnt_q + 16'd1;
                end
              end
              default: begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign job_ready  = job_ready_q;
  assign out_HADDR  = haddr_q;
  assign out_HTRANS = htrans_q;
  assign out_HWRITE = hwrite_q;
  assign out_HSIZE  = 3'b010;
  assign out_HBURST = 3'b000;
  assign out_HWDATA = hwdata_q;
  assign busy       = busy_q;
  assign job_done   = job_done_q;
  assign job_err    = job_err_q;
  assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_cnn_job_sequencer.sv
// tb/tb_cnn_job_sequencer.sv - directed self-checking bench for cnn_job_sequencer
module tb_cnn_job_sequencer;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_img_addr = '0;
  logic [31:0] job_cfg = '0;
  logic [31:0] out_HADDR;
  logic [1:0]  out_HTRANS;
  logic        out_HWRITE;
  logic [2:0]  out_HSIZE;
  logic [2:0]  out_HBURST;
  logic [31:0] out_HWDATA;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
  logic [31:0] HRDATA = '0;
  logic        busy, job_done, job_err;
  logic [15:0] done_cnt;

  cnn_job_sequencer #(.CNN_BASE(BASE), .Q_DEPTH(4), .POLL_GAP(8), .POLL_MAX(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_img_addr(job_img_addr), .job_cfg(job_cfg),
    .out_HADDR(out_HADDR), .out_HTRANS(out_HTRANS), .out_HWRITE(out_HWRITE),
    .out_HSIZE(out_HSIZE), .out_HBURST(out_HBURST), .out_HWDATA(out_HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .busy(busy), .job_done(job_done), .job_err(job_err), .done_cnt(done_cnt)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Slave model controls and transfer log
  int          waits = 0;
  bit          stall_all = 0;
  bit          err_armed = 0;
  logic [31:0] err_addr = '0;
  logic [31:0] status_fifo[$];
  logic [31:0] status_dflt = 32'h2;
  int          stab_bad = 0;
  int          stab_n = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit          log_wr[$];
  bit          log_err[$];
  int          log_acc[$];
  int          log_done[$];

  initial begin
    bit          dp;
    bit          e;
    logic [31:0] dp_addr;
    logic        dp_wr;
    int          wl, acc;
    dp = 0; wl = 0; acc = 0; dp_addr = '0; dp_wr = 0;
    forever begin
      @(negedge HCLK);
      HRESP = 2'b00;
      e = 0;
      if (HRESET) begin
        dp = 0;
        HREADY = 1'b1;
      end else if (dp) begin
        if (stall_all) begin
          HREADY = 1'b0;
        end else if (wl > 0) begin
          HREADY = 1'b0;
          wl--;
          stab_n++;
          if (out_HADDR !== dp_addr || out_HWRITE !== dp_wr) stab_bad++;
        end else begin
          HREADY = 1'b1;
          if (err_armed && dp_addr == err_addr) begin
            HRESP = 2'b01;
            err_armed = 0;
            e = 1;
          end
          if (!dp_wr) HRDATA = (status_fifo.size() > 0) ? status_fifo.pop_front() : status_dflt;
          log_addr.push_back(dp_addr);
          log_wr.push_back(dp_wr);
          log_data.push_back(dp_wr ? out_HWDATA : HRDATA);
          log_err.push_back(e);
          log_acc.push_back(acc);
          log_done.push_back(cyc + 1);
          dp = 0;
        end
      end else if (out_HTRANS == 2'b10) begin
        if (stall_all) begin
          HREADY = 1'b0;
        end else begin
          HREADY = 1'b1;
          dp = 1;
          dp_addr = out_HADDR;
          dp_wr = out_HWRITE;
          wl = waits;
          acc = cyc + 1;
        end
      end else begin
        HREADY = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    chk({tag, "_present"}, 32'(log_addr.size() > i), 32'h1);
    if (log_addr.size() > i) begin
      chk({tag, "_addr"}, log_addr[i], a);
      chk({tag, "_wr"}, 32'(log_wr[i]), 32'(w));
      chk({tag, "_data"}, log_data[i], d);
    end
  endtask

  task automatic clear_log();
    log_addr = {}; log_data = {}; log_wr = {}; log_err = {}; log_acc = {}; log_done = {};
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] c);
    int t;
    t = 0;
    @(negedge HCLK);
    while (!job_ready && t < 200) begin
      @(negedge HCLK);
      t++;
    end
    chk("push_ready_bound", 32'(t < 200), 32'h1);
    job_valid = 1'b1;
    job_img_addr = a;
    job_cfg = c;
    @(negedge HCLK);
    job_valid = 1'b0;
  endtask

  task automatic wait_events(input int n, input int budget, output int nd, output int ne);
    int t;
    t = 0; nd = 0; ne = 0;
    while (t < budget && !((nd + ne) >= n && !busy)) begin
      @(negedge HCLK);
      t++;
      if (job_done) nd++;
      if (job_err) ne++;
    end
    chk("wait_bound", 32'(t < budget), 32'h1);
  endtask

  function automatic int count_reads();
    int r;
    r = 0;
    foreach (log_wr[i]) if (!log_wr[i]) r++;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, ne, base, t, k, r;
    bit hit;
    logic [31:0] img_exp[5];

    // Reset values
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 32'(out_HTRANS), 32'h0);
    chk("rst_haddr", out_HADDR, 32'h0);
    chk("rst_hwdata", out_HWDATA, 32'h0);
    chk("rst_hwrite", 32'(out_HWRITE), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_job_done", 32'(job_done), 32'h0);
    chk("rst_job_err", 32'(job_err), 32'h0);
    chk("rst_done_cnt", 32'(done_cnt), 32'h0);
    chk("rst_job_ready", 32'(job_ready), 32'h1);
    chk("hsize", 32'(out_HSIZE), 32'h2);
    chk("hburst", 32'(out_HBURST), 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Single job, zero-wait slave, done on first poll
    clear_log();
    status_fifo.push_back(32'h2);
    job_valid = 1'b1;
    job_img_addr = 32'h0000_0100;
    job_cfg = 32'h0000_0003;
    n = 0;
    for (int kk = 1; kk <= 40 && n == 0; kk++) begin
      @(negedge HCLK);
      job_valid = 1'b0;
      if (job_done) n = kk;
    end
    chk("t1_latency", 32'(n), 32'd12);
    chk("t1_busy_fin", 32'(busy), 32'h1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    @(negedge HCLK);
    chk("t1_done_pulse_end", 32'(job_done), 32'h0);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    chk("t1_log_size", 32'(log_addr.size()), 32'd5);
    chk_log("t1_img", 0, BASE + 32'h8, 1'b1, 32'h100);
    chk_log("t1_cfg", 1, BASE + 32'hC, 1'b1, 32'h3);
    chk_log("t1_start", 2, BASE + 32'h0, 1'b1, 32'h1);
    chk_log("t1_status", 3, BASE + 32'h4, 1'b0, 32'h2);
    chk_log("t1_clear", 4, BASE + 32'h0, 1'b1, 32'h2);

    // Wait states and multiple polls
    clear_log();
    waits = 3;
    stab_bad = 0;
    stab_n = 0;
    status_fifo.push_back(32'h0);
    status_fifo.push_back(32'h0);
    status_fifo.push_back(32'h2);
    push(32'h0000_0200, 32'h0000_0055);
    wait_events(1, 600, nd, ne);
    waits = 0;
    chk("t2_done_once", 32'(nd), 32'd1);
    chk("t2_no_err", 32'(ne), 32'd0);
    chk("t2_stable", 32'(stab_bad), 32'd0);
    chk("t2_wait_cycles", 32'(stab_n), 32'd21);
    chk("t2_reads", 32'(count_reads()), 32'd3);
    chk("t2_log_size", 32'(log_addr.size()), 32'd7);
    chk_log("t2_img", 0, BASE + 32'h8, 1'b1, 32'h200);
    chk_log("t2_cfg", 1, BASE + 32'hC, 1'b1, 32'h55);
    chk_log("t2_start", 2, BASE + 32'h0, 1'b1, 32'h1);
    chk_log("t2_rd0", 3, BASE + 32'h4, 1'b0, 32'h0);
    chk_log("t2_rd1", 4, BASE + 32'h4, 1'b0, 32'h0);
    chk_log("t2_rd2", 5, BASE + 32'h4, 1'b0, 32'h2);
    chk_log("t2_clear", 6, BASE + 32'h0, 1'b1, 32'h2);
    if (log_addr.size() == 7) begin
      chk("t2_gap0", 32'((log_acc[4] - log_done[3] - 1) >= 8), 32'h1);
      chk("t2_gap1", 32'((log_acc[5] - log_done[4] - 1) >= 8), 32'h1);
    end
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);

    // Queue full while the bus is stalled, then drain in order
    clear_log();
    stall_all = 1;
    base = int'(done_cnt);
    img_exp = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    for (int j = 0; j < 4; j++) push(img_exp[j], 32'h10 + 32'(j));
    chk("t3_ready_before_full", 32'(job_ready), 32'h1);
    push(img_exp[4], 32'h14);
    chk("t3_ready_full", 32'(job_ready), 32'h0);
    @(negedge HCLK);
    job_valid = 1'b1;
    job_img_addr = 32'h6000;
    job_cfg = 32'h16;
    repeat (4) @(negedge HCLK);
    chk("t3_ready_held", 32'(job_ready), 32'h0);
    job_valid = 1'b0;
    chk("t3_stalled_busy", 32'(busy), 32'h1);
    chk("t3_no_xfers", 32'(log_addr.size()), 32'd0);
    stall_all = 0;
    wait_events(5, 3000, nd, ne);
    chk("t3_done5", 32'(nd), 32'd5);
    chk("t3_done_cnt", 32'(done_cnt), 32'(base + 5));
    k = 0;
    foreach (log_addr[i]) begin
      if (log_addr[i] == BASE + 32'h8) begin
        if (k < 5) chk("t3_order", log_data[i], img_exp[k]);
        k++;
      end
    end
    chk("t3_img_writes", 32'(k), 32'd5);

    // Bus error during the CFG write aborts only that job
    clear_log();
    base = int'(done_cnt);
    err_addr = BASE + 32'hC;
    err_armed = 1;
    push(32'h7000, 32'h77);
    push(32'h8000, 32'h88);
    wait_events(2, 600, nd, ne);
    chk("t4_err_once", 32'(ne), 32'd1);
    chk("t4_done_once", 32'(nd), 32'd1);
    chk("t4_done_cnt", 32'(done_cnt), 32'(base + 1));
    chk("t4_log_size", 32'(log_addr.size()), 32'd7);
    chk_log("t4_img_a", 0, BASE + 32'h8, 1'b1, 32'h7000);
    chk_log("t4_cfg_a", 1, BASE + 32'hC, 1'b1, 32'h77);
    if (log_err.size() > 1) chk("t4_err_flag", 32'(log_err[1]), 32'h1);
    chk_log("t4_img_b", 2, BASE + 32'h8, 1'b1, 32'h8000);
    chk_log("t4_cfg_b", 3, BASE + 32'hC, 1'b1, 32'h88);
    chk_log("t4_start_b", 4, BASE + 32'h0, 1'b1, 32'h1);
    chk_log("t4_clear_b", 6, BASE + 32'h0, 1'b1, 32'h2);

`ifdef CNN_JOB_SEQ_POLL_TIMEOUT_EN
    // Poll timeout with STATUS never done
    clear_log();
    status_dflt = 32'h0;
    base = int'(done_cnt);
    push(32'h9000, 32'h99);
    wait_events(1, 1000, nd, ne);
    status_dflt = 32'h2;
    chk("t5_err", 32'(ne), 32'd1);
    chk("t5_no_done", 32'(nd), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'(base));
    chk("t5_reads", 32'(count_reads()), 32'd4);
    chk("t5_log_size", 32'(log_addr.size()), 32'd8);
    chk_log("t5_stop", 7, BASE + 32'h0, 1'b1, 32'h0);
`endif

    // Reset under traffic, during the CFG address phase
    clear_log();
    push(32'hA000, 32'hA);
    push(32'hB000, 32'hB);
    hit = 0;
    t = 0;
    while (!hit && t < 100) begin
      if (out_HTRANS == 2'b10 && out_HADDR == BASE + 32'hC) hit = 1;
      else begin
        @(negedge HCLK);
        t++;
      end
    end
    chk("t6_reached_cfg", 32'(hit), 32'h1);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("t6_htrans", 32'(out_HTRANS), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_job_ready", 32'(job_ready), 32'h1);
    chk("t6_done_cnt", 32'(done_cnt), 32'h0);
    chk("t6_job_done", 32'(job_done), 32'h0);
    r = 0;
    repeat (30) begin
      @(negedge HCLK);
      if (job_done || busy || job_err) r++;
    end
    chk("t6_quiet", 32'(r), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
